// File: rtl/score_event_tx.sv
// score_event_tx: latches player/gold and player/diamond overlaps per frame,
// queues them in small saturating counters and replays them as spaced,
// never-coincident single-cycle eat pulses for the score block.
// Optional build macro: SCORE_DIAMOND_PRIORITY_EN (diamond always wins when
// both event types are pending; otherwise the types alternate round-robin).
module score_event_tx #(
    parameter int unsigned MAX_PENDING = 7,
    parameter int unsigned GAP         = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic startOfFrame,
    input  logic player_dr,
    input  logic gold_dr,
    input  logic diamond_dr,
    output logic player_eat_gold,
    output logic player_eat_dimond,
    output logic gold_collision,
    output logic diamond_collision,
    output logic overflow
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_PENDING);
    localparam logic [2:0] GAP_CNT = 3'(GAP);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EMIT_G,
        ST_EMIT_D,
        ST_GAP
    } state_t;

    state_t     state, state_next;
    logic [2:0] gap_cnt, gap_cnt_next;
    logic       last_dia, last_dia_next;   // 0: gold served last, 1: diamond

    logic       gold_hit, diamond_hit;
    logic [2:0] pend_gold, pend_dia;
    logic       gold_now, diamond_now;
    logic       inc_gold, inc_dia, dec_gold, dec_dia;
    logic       any_pending, pick_dia;

    assign gold_now    = player_dr & gold_dr;
    assign diamond_now = player_dr & diamond_dr;
    assign inc_gold    = startOfFrame & gold_hit;
    assign inc_dia     = startOfFrame & diamond_hit;
    assign dec_gold    = (state_next == ST_EMIT_G);
    assign dec_dia     = (state_next == ST_EMIT_D);

    // Per-frame hit flags and the post-frame collision strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gold_hit          <= 1'b0;
            diamond_hit       <= 1'b0;
            gold_collision    <= 1'b0;
            diamond_collision <= 1'b0;
        end else begin
            gold_collision    <= inc_gold;
            diamond_collision <= inc_dia;
            if (startOfFrame) begin
                // a hit on the boundary cycle belongs to the frame just starting
                gold_hit    <= gold_now;
                diamond_hit <= diamond_now;
            end else begin
                gold_hit    <= gold_hit | gold_now;
                diamond_hit <= diamond_hit | diamond_now;
            end
        end
    end

    // Saturating pending-event counters and the sticky overflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_gold <= '0;
            pend_dia  <= '0;
            overflow  <= 1'b0;
        end else begin
            if (inc_gold && !dec_gold) begin
                if (pend_gold == MAX_CNT) overflow  <= 1'b1;
                else                      pend_gold <= pend_gold + 3'd1;
            end else if (!inc_gold && dec_gold) begin
                pend_gold <= pend_gold - 3'd1;
            end

            if (inc_dia && !dec_dia) begin
                if (pend_dia == MAX_CNT) overflow <= 1'b1;
                else                     pend_dia <= pend_dia + 3'd1;
            end else if (!inc_dia && dec_dia) begin
                pend_dia <= pend_dia - 3'd1;
            end
        end
    end

    // Arbitration between pending event types
    always_comb begin
        any_pending = (pend_gold != '0) || (pend_dia != '0);
`ifdef SCORE_DIAMOND_PRIORITY_EN
        pick_dia    = (pend_dia != '0);
`else
        pick_dia    = (pend_dia != '0) && ((pend_gold == '0) || !last_dia);
`endif
    end

    // Emitter state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            gap_cnt  <= '0;
            last_dia <= 1'b0;
        end else begin
            state    <= state_next;
            gap_cnt  <= gap_cnt_next;
            last_dia <= last_dia_next;
        end
    end

    // Emitter next-state logic and Moore pulse outputs
    always_comb begin
        state_next        = state;
        gap_cnt_next      = gap_cnt;
        last_dia_next     = last_dia;
        player_eat_gold   = 1'b0;
        player_eat_dimond = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_pending) begin
                    state_next    = pick_dia ? ST_EMIT_D : ST_EMIT_G;
                    last_dia_next = pick_dia;
                end
            end
            ST_EMIT_G: begin
                player_eat_gold = 1'b1;
                state_next      = ST_GAP;
                gap_cnt_next    = GAP_CNT;
            end
            ST_EMIT_D: begin
                player_eat_dimond = 1'b1;
                state_next        = ST_GAP;
                gap_cnt_next      = GAP_CNT;
            end
            ST_GAP: begin
                if (gap_cnt <= 3'd1) begin
                    if (any_pending) begin
                        state_next    = pick_dia ? ST_EMIT_D : ST_EMIT_G;
                        last_dia_next = pick_dia;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    gap_cnt_next = gap_cnt - 3'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_score_event_tx.sv
// Testbench for score_event_tx: directed scenarios plus random traffic,
// all checked against a cycle-level behavioural model of the event rules.
module tb_score_event_tx;

    localparam int MAXP = 7;
    localparam int GAPV = 2;
`ifdef SCORE_DIAMOND_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic startOfFrame = 1'b0;
    logic player_dr = 1'b0;
    logic gold_dr = 1'b0;
    logic diamond_dr = 1'b0;
    logic player_eat_gold, player_eat_dimond, gold_collision, diamond_collision, overflow;

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    // model state: values visible during the current cycle
    bit m_ghit, m_dhit, m_gcol, m_dcol, m_ovf, m_eg, m_ed, m_last_dia;
    int m_pg, m_pd, m_lastpulse;

    always #5 clk = ~clk;

    score_event_tx #(.MAX_PENDING(MAXP), .GAP(GAPV)) dut (
        .clk(clk),
        .reset(reset),
        .startOfFrame(startOfFrame),
        .player_dr(player_dr),
        .gold_dr(gold_dr),
        .diamond_dr(diamond_dr),
        .player_eat_gold(player_eat_gold),
        .player_eat_dimond(player_eat_dimond),
        .gold_collision(gold_collision),
        .diamond_collision(diamond_collision),
        .overflow(overflow)
    );

    function automatic logic [4:0] outs();
        return {player_eat_gold, player_eat_dimond, gold_collision, diamond_collision, overflow};
    endfunction

    function automatic logic [4:0] expv();
        return {m_eg, m_ed, m_gcol, m_dcol, m_ovf};
    endfunction

    task automatic model_reset();
        m_ghit = 0; m_dhit = 0; m_gcol = 0; m_dcol = 0; m_ovf = 0;
        m_eg = 0; m_ed = 0; m_last_dia = 0;
        m_pg = 0; m_pd = 0; m_lastpulse = -100;
    endtask

    // One clock edge of the event rules: a pulse may start GAPV+1 cycles after
    // the previous one, decided from the counts visible one cycle earlier.
    task automatic model_step(input bit sof, input bit pl, input bit go, input bit di);
        bit hg, hd, dg, dd, pick;
        int ng, nd;
        hg = pl & go;
        hd = pl & di;
        dg = 0; dd = 0;
        if (cyc >= m_lastpulse + GAPV && (m_pg > 0 || m_pd > 0)) begin
            if (m_pg > 0 && m_pd > 0) pick = PRIO ? 1'b1 : !m_last_dia;
            else                      pick = (m_pd > 0);
            dg = !pick; dd = pick;
            m_last_dia = pick;
            m_lastpulse = cyc + 1;
        end
        ng = m_pg + int'(sof && m_ghit) - int'(dg);
        nd = m_pd + int'(sof && m_dhit) - int'(dd);
        if (ng > MAXP) begin ng = MAXP; m_ovf = 1; end
        if (nd > MAXP) begin nd = MAXP; m_ovf = 1; end
        m_pg = ng; m_pd = nd;
        m_gcol = sof && m_ghit;
        m_dcol = sof && m_dhit;
        m_ghit = sof ? hg : (m_ghit | hg);
        m_dhit = sof ? hd : (m_dhit | hd);
        m_eg = dg; m_ed = dd;
    endtask

    // drive one cycle of inputs, advance the model and the DUT by one edge
    task automatic tick(input bit sof, input bit pl, input bit go, input bit di);
        startOfFrame = sof; player_dr = pl; gold_dr = go; diamond_dr = di;
        if (reset) model_reset();
        else       model_step(sof, pl, go, di);
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(0, 0, 0, 0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick(0, 0, 0, 0);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (outs() !== 5'b0) $display("FAIL reset_idle cyc=%0d got=%b exp=00000", cyc, outs());
            else passed++;
            tick(0, 0, 0, 0);
        end
    endtask

    task automatic test_single_gold();
        int npulse;
        repeat (2) tick(0, 0, 0, 0);
        repeat (3) tick(0, 1, 1, 0);
        repeat (2) tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        npulse = 0;
        for (int k = 1; k <= 10; k++) begin
            checks++;
            if (outs() !== expv()) $display("FAIL single_model k=%0d got=%b exp=%b", k, outs(), expv());
            else passed++;
            checks++;
            if (gold_collision !== (k == 1)) $display("FAIL single_gcol k=%0d got=%b exp=%b", k, gold_collision, (k == 1));
            else passed++;
            checks++;
            if (player_eat_gold !== (k == 2)) $display("FAIL single_pulse k=%0d got=%b exp=%b", k, player_eat_gold, (k == 2));
            else passed++;
            if (player_eat_gold) npulse++;
            tick(0, 0, 0, 0);
        end
        checks++;
        if (npulse !== 1) $display("FAIL single_count got=%0d exp=1", npulse);
        else passed++;
    endtask

    task automatic test_both_types();
        int dpos, gpos, npulse;
        do_reset();
        repeat (2) tick(0, 1, 1, 1);
        tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        dpos = -1; gpos = -1; npulse = 0;
        for (int k = 1; k <= 12; k++) begin
            checks++;
            if (outs() !== expv()) $display("FAIL both_model k=%0d got=%b exp=%b", k, outs(), expv());
            else passed++;
            checks++;
            if (player_eat_gold && player_eat_dimond) $display("FAIL both_overlap k=%0d got=11 exp=not both", k);
            else passed++;
            if (player_eat_dimond && dpos < 0) dpos = k;
            if (player_eat_gold && gpos < 0) gpos = k;
            if (player_eat_gold || player_eat_dimond) npulse++;
            tick(0, 0, 0, 0);
        end
        checks++;
        if (dpos !== 2) $display("FAIL both_dia_pos got=%0d exp=2", dpos);
        else passed++;
        checks++;
        if (gpos !== 5) $display("FAIL both_gold_pos got=%0d exp=5", gpos);
        else passed++;
        checks++;
        if (npulse !== 2) $display("FAIL both_count got=%0d exp=2", npulse);
        else passed++;
    endtask

    // second frame boundary lands while gold from the first frame is still queued
    task automatic test_repeat_frame();
        logic [1:0] at5;
        do_reset();
        repeat (2) tick(0, 1, 1, 1);
        tick(1, 0, 0, 0);
        at5 = 2'b00;
        for (int k = 1; k <= 16; k++) begin
            checks++;
            if (outs() !== expv()) $display("FAIL repeat_model k=%0d got=%b exp=%b", k, outs(), expv());
            else passed++;
            if (k == 5) at5 = {player_eat_gold, player_eat_dimond};
            if (k == 1 || k == 2) tick(0, 1, 1, 1);
            else if (k == 3)      tick(1, 0, 0, 0);
            else                  tick(0, 0, 0, 0);
        end
        checks++;
        if (at5 !== (PRIO ? 2'b01 : 2'b10)) $display("FAIL repeat_first got=%b exp=%b", at5, (PRIO ? 2'b01 : 2'b10));
        else passed++;
        repeat (12) tick(0, 0, 0, 0);
    endtask

    task automatic test_boundary_hit();
        int gpos;
        do_reset();
        repeat (2) tick(0, 0, 0, 0);
        tick(1, 1, 1, 0);
        for (int k = 1; k <= 10; k++) begin
            checks++;
            if (outs() !== 5'b0) $display("FAIL boundary_quiet k=%0d got=%b exp=00000", k, outs());
            else passed++;
            tick(0, 0, 0, 0);
        end
        tick(1, 0, 0, 0);
        gpos = -1;
        for (int k = 1; k <= 10; k++) begin
            checks++;
            if (outs() !== expv()) $display("FAIL boundary_model k=%0d got=%b exp=%b", k, outs(), expv());
            else passed++;
            if (player_eat_gold) begin
                checks++;
                if (gpos >= 0) $display("FAIL boundary_extra k=%0d got=second pulse exp=one pulse", k);
                else passed++;
                gpos = k;
            end
            tick(0, 0, 0, 0);
        end
        checks++;
        if (gpos !== 2) $display("FAIL boundary_pos got=%0d exp=2", gpos);
        else passed++;
    endtask

    task automatic test_overflow();
        int n, cnt, prev;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            checks++;
            if (outs() !== expv()) $display("FAIL ovf_model i=%0d got=%b exp=%b", i, outs(), expv());
            else passed++;
            tick((i % 2) == 1, (i % 2) == 0, 1'b1, 1'b0);
        end
        checks++;
        if (overflow !== 1'b1) $display("FAIL ovf_flag got=%b exp=1", overflow);
        else passed++;
        n = m_pg;
        cnt = 0; prev = -1;
        for (int j = 0; j < 40; j++) begin
            checks++;
            if (outs() !== expv()) $display("FAIL drain_model j=%0d got=%b exp=%b", j, outs(), expv());
            else passed++;
            if (player_eat_gold) begin
                if (prev >= 0) begin
                    checks++;
                    if (j - prev !== 3) $display("FAIL drain_spacing j=%0d got=%0d exp=3", j, j - prev);
                    else passed++;
                end
                prev = j;
                if (j >= 1) cnt++;
            end
            tick(0, 0, 0, 0);
        end
        checks++;
        if (cnt !== n) $display("FAIL drain_count got=%0d exp=%0d", cnt, n);
        else passed++;
        checks++;
        if (overflow !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", overflow);
        else passed++;
    endtask

    task automatic test_reset_mid();
        bit seen;
        for (int f = 0; f < 3; f++) begin
            tick(0, 1, 1, 0);
            tick(1, 0, 0, 0);
        end
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (player_eat_gold) seen = 1;
            else tick(0, 0, 0, 0);
        end
        checks++;
        if (!seen) $display("FAIL rstmid_wait got=no gold pulse exp=gold pulse within 20 cycles");
        else passed++;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (outs() !== 5'b0) $display("FAIL rstmid_async got=%b exp=00000", outs());
        else passed++;
        tick(0, 0, 0, 0);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (outs() !== 5'b0) $display("FAIL rstmid_after k=%0d got=%b exp=00000", k, outs());
            else passed++;
            tick(0, 0, 0, 0);
        end
    endtask

    task automatic test_random();
        bit s, p, g, d;
        do_reset();
        for (int k = 0; k < 600; k++) begin
            checks++;
            if (outs() !== expv()) $display("FAIL random_model cyc=%0d got=%b exp=%b", cyc, outs(), expv());
            else passed++;
            checks++;
            if (player_eat_gold && player_eat_dimond) $display("FAIL random_overlap cyc=%0d got=11 exp=not both", cyc);
            else passed++;
            s = ($urandom_range(7) == 0);
            p = ($urandom_range(1) == 0);
            g = ($urandom_range(9) < 3);
            d = ($urandom_range(9) < 3);
            tick(s, p, g, d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        #1;
        test_reset();
        test_single_gold();
        test_both_types();
        test_repeat_frame();
        test_boundary_hit();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
